// File: rtl/reg_cmd_decoder.sv
// Register-access command engine. It takes one command word per strobe and
// decodes it as {opcode, addr, data}. It then runs a write, a read or an
// overflow clear against a small register bank. Each command produces one
// {status, addr, data} response over a valid/ready handshake. A one-deep
// pending slot holds a command that arrives while a response is stalled.
//
// state | meaning
// IDLE  | waiting for a command strobe
// EXEC  | decode, perform the write, register the response (one cycle)
// RESP  | response valid and held until downstream accepts it
module reg_cmd_decoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 16'hA5C3,
    localparam int CMD_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           i_reset,
    input  logic [CMD_WIDTH-1:0]           i_cmd_data,
    input  logic                           i_cmd_dv,
    output logic [CMD_WIDTH-1:0]           o_rsp_data,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic                           o_busy,
    output logic                           o_overflow
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_CLEAR = 8'h43;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_ADDR   = 8'h01;
    localparam logic [7:0] ST_OPCODE = 8'h02;
    localparam logic [7:0] ST_RO     = 8'h03;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state;
    logic [CMD_WIDTH-1:0]   cmd;
    logic [CMD_WIDTH-1:0]   pend;
    logic                   pend_valid;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

    logic [7:0]             opcode;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  data;
    logic [IDX_W-1:0]       idx;
    logic                   addr_bad;
    logic [7:0]             status;
    logic [DATA_WIDTH-1:0]  rsp_field;
    logic                   do_write;
    logic                   do_clear;
    logic                   handshake;
    logic                   drop;

    // Decode the latched command into status, response data and actions.
    // Register 0 never takes a write, so reading it returns ID_VALUE.
    always_comb begin
        opcode    = cmd[CMD_WIDTH-1 -: 8];
        addr      = cmd[DATA_WIDTH +: ADDR_WIDTH];
        data      = cmd[DATA_WIDTH-1:0];
        idx       = addr[IDX_W-1:0];
        addr_bad  = (32'(addr) >= NUM_REGS);
        status    = ST_OK;
        rsp_field = '0;
        do_write  = 1'b0;
        do_clear  = 1'b0;
        case (opcode)
            OP_WRITE: begin
                if (addr_bad) begin
                    status = ST_ADDR;
                end else if (idx == '0) begin
                    status = ST_RO;
                end else begin
                    do_write  = 1'b1;
                    rsp_field = data;
                end
            end
            OP_READ: begin
                if (addr_bad) begin
                    status = ST_ADDR;
                end else begin
                    rsp_field = regs[idx];
                end
            end
            OP_CLEAR: do_clear = 1'b1;
            default:  status = ST_OPCODE;
        endcase
    end

    // A strobe is dropped only when the pending slot is full and is not
    // being freed by a handshake in this same cycle.
    always_comb begin
        handshake = (state == RESP) && i_rsp_ready;
        drop      = i_cmd_dv && (state != IDLE) && pend_valid && !handshake;
    end

    // Command FSM, pending slot, register bank and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cmd         <= '0;
            pend        <= '0;
            pend_valid  <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_valid <= 1'b0;
            o_overflow  <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= (k == 0) ? ID_VALUE : '0;
            end
        end else begin
            // A drop in the same cycle as a clear wins, so the flag stays set.
            if (drop) begin
                o_overflow <= 1'b1;
            end else if ((state == EXEC) && do_clear) begin
                o_overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_cmd_dv) begin
                        cmd   <= i_cmd_data;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (do_write) begin
                        regs[idx] <= data;
                    end
                    o_rsp_data  <= {status, addr, rsp_field};
                    o_rsp_valid <= 1'b1;
                    state       <= RESP;
                    if (i_cmd_dv && !pend_valid) begin
                        pend       <= i_cmd_data;
                        pend_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        if (pend_valid) begin
                            cmd   <= pend;
                            state <= EXEC;
                            if (i_cmd_dv) begin
                                pend <= i_cmd_data;
                            end else begin
                                pend_valid <= 1'b0;
                            end
                        end else if (i_cmd_dv) begin
                            // The slot is empty, so the new command can run next.
                            cmd   <= i_cmd_data;
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (i_cmd_dv && !pend_valid) begin
                        pend       <= i_cmd_data;
                        pend_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule
